secuenciador_control_legion: RTL and testbench
==============================================

Name: secuenciador_control_legion

Overview:
- Multi-cycle control unit for the 9-bit-instruction microprocessor datapath.
- Owns the program counter and fetches instructions from instruction memory.
- Decodes each instruction and sequences the register file, ALU and data-memory bus through FETCH/DECODE/EXEC/MEM.
- The FSM advances only on a work tick derived from the programmable work frequency divider; the datapath holds no sequencing logic of its own.

Parameters:
- ANCHO_PC, 8, program-counter and instruction-address width
- ANCHO_DIV, 32, width of the work-frequency divider count

Ports:
- i_Clk  in  1  system clock; all state updates on its rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Instrucciones  in  9  instruction word at o_Direcciones_Instrucciones; [8:6] opcode, [5:3] field A, [2:0] field B
- i_Frec_de_trabajo  in  ANCHO_DIV  tick divisor; 0 or 1 means a tick every clock
- i_Reg_A_Dato  in  8  register-file read data for o_Reg_Sel_A (jump target)
- i_Mem_Listo  in  1  data-memory done strobe
- o_Direcciones_Instrucciones  out  ANCHO_PC  program counter
- o_Reg_Sel_A  out  3  register-file read port A select
- o_Reg_Sel_B  out  3  register-file read port B select
- o_Reg_Sel_W  out  3  register-file write select
- o_Reg_Wr_En  out  1  register write strobe, one clock wide
- o_Reg_Wr_Src  out  3  write source: 0 memory, 1 immediate, 2 regB, 3 ALU, 4 PC+1
- o_ALU_Op  out  3  ALU function (IR[2:0] for MATH, else 0)
- o_Mem_Req  out  1  data-memory request
- o_Lectura_Escritura  out  1  data-bus direction: 0 read, 1 write
- o_Halt  out  1  processor halted
- o_Estado  out  3  current FSM state, for debug

Behaviour:
- Reset (i_Rst=1 at edge): PC=0, IR=0, divider=0, state FETCH.
- Reset values of all other outputs: every remaining output 0.
- Reset has priority over everything, including mid-MEM; o_Mem_Req drops the cycle after reset.
- Divider:
  - Counts 0..D-1 with D=i_Frec_de_trabajo.
  - tick=1 when count==D-1, then count returns to 0.
  - D<=1: tick=1 every clock.
  - A change of D takes effect at the next wrap.
- Encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
- FETCH (on tick): IR<=i_Instrucciones; go to DECODE.
- DECODE (on tick):
  - Register o_Reg_Sel_A=IR[5:3], o_Reg_Sel_B=IR[2:0], o_ALU_Op; go to EXEC.
  - Opcode 111 goes to HALT instead.
- EXEC (on tick), by opcode:
  - 000 LOAD_M: o_Mem_Req=1, o_Lectura_Escritura=0, go to MEM. Address comes from regB.
  - 001 LOAD_I: Rd=IR[5:3] <- zero-extended IR[2:0], src 1.
  - 010 STORE: o_Mem_Req=1, o_Lectura_Escritura=1, go to MEM. Address is regA, data is regB.
  - 011 NOP: no write.
  - 100 MOVE: R[5:3] <- R[2:0], src 2.
  - 101 MATH: R[5:3] <- ALU, src 3.
  - 110 JUMP: PC <- i_Reg_A_Dato. If IR[0]=1, also R7 <- old PC+1 (src 4, Sel_W=7).
  - All non-memory opcodes go to FETCH. Non-jump opcodes do PC <- PC+1.
- MEM:
  - o_Mem_Req stays high and i_Mem_Listo is sampled every clock, independent of tick.
  - On the first clock with i_Mem_Listo=1: drop o_Mem_Req; PC+1; go to FETCH.
  - For LOAD_M, also pulse a write with src 0.
  - o_Lectura_Escritura returns to 0 with the request.
  - No timeout; MEM waits indefinitely.
- Write strobe: o_Reg_Wr_En is high exactly one i_Clk cycle, the cycle after the completing edge. o_Reg_Sel_W and o_Reg_Wr_Src are valid in that same cycle.
- PC arithmetic: modulo 2^ANCHO_PC; 0xFF+1 = 0x00. Link value for JUMP is also modulo 2^ANCHO_PC.
- HALT: o_Halt=1; PC frozen; no requests or writes; exit only by reset.
- Tick and i_Mem_Listo in the same cycle while in MEM: memory completion wins, and the tick is not carried over.

Test Plan:
- D=1; program LOAD_I 001_010_101, NOP 011_000_000 -> 3 ticks per instruction; Wr_En pulse with Sel_W=2, Src=1; PC 0->1->2.
- D=2 -> FSM advances every 2nd clock; first IR capture 2 clocks after reset release; each instruction takes 6 clocks.
- LOAD_M 000_001_100, i_Mem_Listo delayed 5 clocks -> Mem_Req high 5 clocks, Lectura_Escritura=0; Wr_En with Src=0, Sel_W=1; PC advances once.
- STORE 010_010_111 -> Mem_Req=1 and Lectura_Escritura=1 until Listo; no Wr_En.
- JUMP 110_101_001 at PC=0x07, i_Reg_A_Dato=0x40 -> PC=0x40; R7 written with Src=4 (value 0x08).
- Edge cases:
  - PC=0xFF NOP -> PC=0x00.
  - HALT 111_xxx_xxx -> o_Halt=1, PC constant.
  - Reset asserted mid-MEM -> next cycle all outputs 0, state FETCH.

Source files
------------

// File: rtl/secuenciador_control_legion_if.sv
// -----------------------------------------------------------------------------
// secuenciador_control_legion_if
// Bundle of the signals between the multi-cycle control unit and the rest of the
// 9-bit-instruction processor (instruction memory, register file, ALU and the
// data-memory bus). Signal names keep the control-unit point of view: i_* are
// driven by the datapath side, o_* are driven by the control unit.
//
//   i_Instrucciones             instruction word at o_Direcciones_Instrucciones
//   i_Frec_de_trabajo           work-tick divisor (0 or 1: tick every clock)
//   i_Reg_A_Dato                register-file read data for o_Reg_Sel_A
//   i_Mem_Listo                 data-memory done strobe
//   o_Direcciones_Instrucciones program counter
//   o_Reg_Sel_A/B/W             register-file read A / read B / write selects
//   o_Reg_Wr_En, o_Reg_Wr_Src   one-clock write strobe and write source
//   o_ALU_Op                    ALU function
//   o_Mem_Req, o_Lectura_Escritura  data-memory request and direction (1 = write)
//   o_Halt, o_Estado            halted flag and current FSM state
//
// Modports: master = control unit, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface secuenciador_control_legion_if #(
    parameter int ANCHO_PC  = 8,
    parameter int ANCHO_DIV = 32
);
    logic [8:0]           i_Instrucciones;
    logic [ANCHO_DIV-1:0] i_Frec_de_trabajo;
    logic [7:0]           i_Reg_A_Dato;
    logic                 i_Mem_Listo;
    logic [ANCHO_PC-1:0]  o_Direcciones_Instrucciones;
    logic [2:0]           o_Reg_Sel_A;
    logic [2:0]           o_Reg_Sel_B;
    logic [2:0]           o_Reg_Sel_W;
    logic                 o_Reg_Wr_En;
    logic [2:0]           o_Reg_Wr_Src;
    logic [2:0]           o_ALU_Op;
    logic                 o_Mem_Req;
    logic                 o_Lectura_Escritura;
    logic                 o_Halt;
    logic [2:0]           o_Estado;

    modport master (
        input  i_Instrucciones, i_Frec_de_trabajo, i_Reg_A_Dato, i_Mem_Listo,
        output o_Direcciones_Instrucciones, o_Reg_Sel_A, o_Reg_Sel_B, o_Reg_Sel_W,
               o_Reg_Wr_En, o_Reg_Wr_Src, o_ALU_Op, o_Mem_Req, o_Lectura_Escritura,
               o_Halt, o_Estado
    );

    modport slave (
        output i_Instrucciones, i_Frec_de_trabajo, i_Reg_A_Dato, i_Mem_Listo,
        input  o_Direcciones_Instrucciones, o_Reg_Sel_A, o_Reg_Sel_B, o_Reg_Sel_W,
               o_Reg_Wr_En, o_Reg_Wr_Src, o_ALU_Op, o_Mem_Req, o_Lectura_Escritura,
               o_Halt, o_Estado
    );
endinterface

// File: rtl/secuenciador_control_legion.sv
// -----------------------------------------------------------------------------
// secuenciador_control_legion
// Multi-cycle control unit for the 9-bit-instruction processor. Owns the program
// counter, fetches and decodes instructions and sequences the register file, ALU
// and data-memory bus through FETCH -> DECODE -> EXEC (-> MEM). The FSM only
// advances on a work tick produced by a programmable divider; the MEM state
// instead polls i_Mem_Listo on every clock.
//
// Ports:
//   i_Clk  system clock (rising edge)
//   i_Rst  synchronous, active-high reset
//   bus    secuenciador_control_legion_if.master (instruction fetch, register
//          file controls, ALU op, data-memory handshake, status)
//
// Instruction word: [8:6] opcode, [5:3] field A, [2:0] field B.
// -----------------------------------------------------------------------------
module secuenciador_control_legion #(
    parameter int ANCHO_PC  = 8,
    parameter int ANCHO_DIV = 32
) (
    input  logic i_Clk,
    input  logic i_Rst,
    secuenciador_control_legion_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4
    } estado_t;

    localparam logic [2:0] OP_LOAD_M = 3'b000;
    localparam logic [2:0] OP_LOAD_I = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_NOP    = 3'b011;
    localparam logic [2:0] OP_MOVE   = 3'b100;
    localparam logic [2:0] OP_MATH   = 3'b101;
    localparam logic [2:0] OP_JUMP   = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [2:0] SRC_MEM  = 3'd0;
    localparam logic [2:0] SRC_IMM  = 3'd1;
    localparam logic [2:0] SRC_REGB = 3'd2;
    localparam logic [2:0] SRC_ALU  = 3'd3;
    localparam logic [2:0] SRC_LINK = 3'd4;

    localparam logic [ANCHO_DIV-1:0] DIV_UNO = 1;
    localparam logic [ANCHO_PC-1:0]  PC_UNO  = 1;

    // Divider state
    logic [ANCHO_DIV-1:0] div_cnt_q;
    logic [ANCHO_DIV-1:0] div_lat_q;
    logic [ANCHO_DIV-1:0] div_eff_d;
    logic                 tick_d;

    // Sequencer state and registered outputs
    estado_t             estado_q;
    logic [8:0]          ir_q;
    logic [ANCHO_PC-1:0] pc_q;
    logic [ANCHO_PC-1:0] pc_inc_d;
    logic [2:0]          sel_a_q;
    logic [2:0]          sel_b_q;
    logic [2:0]          sel_w_q;
    logic                wr_en_q;
    logic [2:0]          wr_src_q;
    logic [2:0]          alu_op_q;
    logic                mem_req_q;
    logic                rw_q;
    logic                halt_q;
    logic [2:0]          opcode_d;

    // The divisor is sampled only at the start of a period (count==0) and held
    // for the rest of it, so a new i_Frec_de_trabajo takes effect at the wrap.
    always_comb begin
        div_eff_d = (div_cnt_q == '0) ? bus.i_Frec_de_trabajo : div_lat_q;
        tick_d    = (div_eff_d <= DIV_UNO) || (div_cnt_q == (div_eff_d - DIV_UNO));
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            div_cnt_q <= '0;
            div_lat_q <= '0;
        end else begin
            div_lat_q <= div_eff_d;
            div_cnt_q <= tick_d ? '0 : (div_cnt_q + DIV_UNO);
        end
    end

    assign pc_inc_d = pc_q + PC_UNO;
    assign opcode_d = ir_q[8:6];

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            estado_q  <= FETCH;
            ir_q      <= '0;
            pc_q      <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            sel_w_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_src_q  <= '0;
            alu_op_q  <= '0;
            mem_req_q <= 1'b0;
            rw_q      <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            // Write strobe is a single-clock pulse after the completing edge.
            wr_en_q <= 1'b0;
            case (estado_q)
                FETCH: begin
                    if (tick_d) begin
                        ir_q     <= bus.i_Instrucciones;
                        estado_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (tick_d) begin
                        sel_a_q  <= ir_q[5:3];
                        sel_b_q  <= ir_q[2:0];
                        alu_op_q <= (opcode_d == OP_MATH) ? ir_q[2:0] : 3'd0;
                        if (opcode_d == OP_HALT) begin
                            halt_q   <= 1'b1;
                            estado_q <= HALT;
                        end else begin
                            estado_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (tick_d) begin
                        estado_q <= FETCH;
                        pc_q     <= pc_inc_d;
                        case (opcode_d)
                            OP_LOAD_M: begin
                                mem_req_q <= 1'b1;
                                rw_q      <= 1'b0;
                                pc_q      <= pc_q;
                                estado_q  <= MEM;
                            end
                            OP_STORE: begin
                                mem_req_q <= 1'b1;
                                rw_q      <= 1'b1;
                                pc_q      <= pc_q;
                                estado_q  <= MEM;
                            end
                            OP_LOAD_I: begin
                                wr_en_q  <= 1'b1;
                                sel_w_q  <= ir_q[5:3];
                                wr_src_q <= SRC_IMM;
                            end
                            OP_MOVE: begin
                                wr_en_q  <= 1'b1;
                                sel_w_q  <= ir_q[5:3];
                                wr_src_q <= SRC_REGB;
                            end
                            OP_MATH: begin
                                wr_en_q  <= 1'b1;
                                sel_w_q  <= ir_q[5:3];
                                wr_src_q <= SRC_ALU;
                            end
                            OP_JUMP: begin
                                pc_q <= ANCHO_PC'(bus.i_Reg_A_Dato);
                                // Link: the datapath forms PC+1 from the PC it
                                // saw during EXEC, before the jump lands.
                                if (ir_q[0]) begin
                                    wr_en_q  <= 1'b1;
                                    sel_w_q  <= 3'd7;
                                    wr_src_q <= SRC_LINK;
                                end
                            end
                            default: begin
                                // OP_NOP: only the PC advances.
                            end
                        endcase
                    end
                end
                MEM: begin
                    // Completion is polled every clock; a coincident tick is
                    // simply consumed here and not replayed in FETCH.
                    if (bus.i_Mem_Listo) begin
                        mem_req_q <= 1'b0;
                        rw_q      <= 1'b0;
                        pc_q      <= pc_inc_d;
                        estado_q  <= FETCH;
                        if (opcode_d == OP_LOAD_M) begin
                            wr_en_q  <= 1'b1;
                            sel_w_q  <= ir_q[5:3];
                            wr_src_q <= SRC_MEM;
                        end
                    end
                end
                HALT: begin
                    estado_q <= HALT;
                end
                default: begin
                    estado_q <= FETCH;
                end
            endcase
        end
    end

    assign bus.o_Direcciones_Instrucciones = pc_q;
    assign bus.o_Reg_Sel_A                 = sel_a_q;
    assign bus.o_Reg_Sel_B                 = sel_b_q;
    assign bus.o_Reg_Sel_W                 = sel_w_q;
    assign bus.o_Reg_Wr_En                 = wr_en_q;
    assign bus.o_Reg_Wr_Src                = wr_src_q;
    assign bus.o_ALU_Op                    = alu_op_q;
    assign bus.o_Mem_Req                   = mem_req_q;
    assign bus.o_Lectura_Escritura         = rw_q;
    assign bus.o_Halt                      = halt_q;
    assign bus.o_Estado                    = estado_q;

endmodule

// File: tb/tb_secuenciador_control_legion.sv
module tb_secuenciador_control_legion;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secuenciador_control_legion_if #(.ANCHO_PC(8), .ANCHO_DIV(32)) bus ();

    secuenciador_control_legion #(.ANCHO_PC(8), .ANCHO_DIV(32)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    // Instruction memory model: combinational read at the PC.
    logic [8:0] imem [256];
    always_comb bus.i_Instrucciones = imem[bus.o_Direcciones_Instrucciones];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      nm;
        logic [8:0] instr;
        int         pre;      // NOPs executed before the instruction under test
        logic [7:0] rega;
        logic [7:0] pc_exp;
        logic       wr_exp;
        logic [2:0] sel_w_exp;
        logic [2:0] src_exp;
        logic [2:0] sel_a_exp;
        logic [2:0] sel_b_exp;
        logic [2:0] alu_exp;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) imem[i] = 9'b011_000_000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, bus.o_Direcciones_Instrucciones, bus.o_Reg_Sel_A, bus.o_Reg_Sel_B,
                bus.o_Reg_Sel_W, bus.o_Reg_Wr_En, bus.o_Reg_Wr_Src, bus.o_ALU_Op,
                bus.o_Mem_Req, bus.o_Lectura_Escritura, bus.o_Halt, bus.o_Estado};
    endfunction

    initial begin
        //            name           instr            pre  rega   pc     wr  selw src  selA selB alu
        vt[0] = '{"load_i",  9'b001_010_101,   0, 8'h40, 8'h01, 1'b1, 3'd2, 3'd1, 3'd2, 3'd5, 3'd0};
        vt[1] = '{"nop",     9'b011_000_000,   1, 8'h40, 8'h02, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vt[2] = '{"move",    9'b100_011_110,   2, 8'h40, 8'h03, 1'b1, 3'd3, 3'd2, 3'd3, 3'd6, 3'd0};
        vt[3] = '{"math",    9'b101_100_010,   0, 8'h40, 8'h01, 1'b1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd2};
        vt[4] = '{"jump_lnk",9'b110_101_001,   7, 8'h40, 8'h40, 1'b1, 3'd7, 3'd4, 3'd5, 3'd1, 3'd0};
        vt[5] = '{"jump",    9'b110_101_000,   3, 8'h9C, 8'h9C, 1'b0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
        vt[6] = '{"pc_wrap", 9'b011_000_000, 255, 8'h40, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

        bus.i_Frec_de_trabajo = 32'd1;
        bus.i_Reg_A_Dato      = 8'h00;
        bus.i_Mem_Listo       = 1'b0;
        fill_nop();

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;

        // Single-instruction vectors with a tick every clock
        for (int k = 0; k < 7; k++) begin
            fill_nop();
            imem[vt[k].pre] = vt[k].instr;
            bus.i_Reg_A_Dato = vt[k].rega;
            do_reset();
            repeat (3 * vt[k].pre) step();
            chk({vt[k].nm, "_pc_start"}, bus.o_Direcciones_Instrucciones, vt[k].pre % 256);
            step();
            step();
            chk({vt[k].nm, "_exec_state"}, bus.o_Estado, 32'd2);
            chk({vt[k].nm, "_exec_pc"}, bus.o_Direcciones_Instrucciones, vt[k].pre % 256);
            step();
            chk({vt[k].nm, "_pc"}, bus.o_Direcciones_Instrucciones, vt[k].pc_exp);
            chk({vt[k].nm, "_wr_en"}, bus.o_Reg_Wr_En, vt[k].wr_exp);
            if (vt[k].wr_exp) begin
                chk({vt[k].nm, "_sel_w"}, bus.o_Reg_Sel_W, vt[k].sel_w_exp);
                chk({vt[k].nm, "_src"}, bus.o_Reg_Wr_Src, vt[k].src_exp);
            end
            chk({vt[k].nm, "_sel_a"}, bus.o_Reg_Sel_A, vt[k].sel_a_exp);
            chk({vt[k].nm, "_sel_b"}, bus.o_Reg_Sel_B, vt[k].sel_b_exp);
            chk({vt[k].nm, "_alu"}, bus.o_ALU_Op, vt[k].alu_exp);
            chk({vt[k].nm, "_state"}, bus.o_Estado, 32'd0);
            step();
            chk({vt[k].nm, "_wr_pulse_end"}, bus.o_Reg_Wr_En, 32'd0);
        end

        // Divider D=2: tick on every second clock
        fill_nop();
        imem[0] = 9'b001_010_101;
        bus.i_Frec_de_trabajo = 32'd2;
        do_reset();
        step();
        chk("div2_e1_state", bus.o_Estado, 32'd0);
        step();
        chk("div2_e2_state", bus.o_Estado, 32'd1);
        step();
        chk("div2_e3_state", bus.o_Estado, 32'd1);
        step();
        step();
        chk("div2_e5_pc", bus.o_Direcciones_Instrucciones, 32'd0);
        step();
        chk("div2_e6_pc", bus.o_Direcciones_Instrucciones, 32'd1);
        chk("div2_e6_wr", {bus.o_Reg_Wr_En, bus.o_Reg_Sel_W, bus.o_Reg_Wr_Src}, {1'b1, 3'd2, 3'd1});
        step();
        chk("div2_e7_wr", bus.o_Reg_Wr_En, 32'd0);
        repeat (5) step();
        chk("div2_e12_pc", bus.o_Direcciones_Instrucciones, 32'd2);
        bus.i_Frec_de_trabajo = 32'd1;

        // LOAD_M with i_Mem_Listo arriving late
        begin
            int hi;
            fill_nop();
            imem[0] = 9'b000_001_100;
            do_reset();
            repeat (3) step();
            chk("ldm_req", {bus.o_Mem_Req, bus.o_Lectura_Escritura}, {1'b1, 1'b0});
            chk("ldm_state_mem", bus.o_Estado, 32'd3);
            hi = 1;
            for (int i = 0; i < 4; i++) begin
                step();
                if (bus.o_Mem_Req) hi++;
            end
            chk("ldm_req_cycles", hi, 32'd5);
            chk("ldm_still_mem", bus.o_Estado, 32'd3);
            chk("ldm_pc_hold", bus.o_Direcciones_Instrucciones, 32'd0);
            bus.i_Mem_Listo = 1'b1;
            step();
            bus.i_Mem_Listo = 1'b0;
            chk("ldm_done_req", {bus.o_Mem_Req, bus.o_Lectura_Escritura}, 32'd0);
            chk("ldm_done_wr", {bus.o_Reg_Wr_En, bus.o_Reg_Sel_W, bus.o_Reg_Wr_Src}, {1'b1, 3'd1, 3'd0});
            chk("ldm_done_pc", bus.o_Direcciones_Instrucciones, 32'd1);
            chk("ldm_done_state", bus.o_Estado, 32'd0);
            step();
            chk("ldm_wr_end", bus.o_Reg_Wr_En, 32'd0);
            chk("ldm_next_decode", bus.o_Estado, 32'd1);
        end

        // STORE
        fill_nop();
        imem[0] = 9'b010_010_111;
        do_reset();
        repeat (3) step();
        chk("st_req", {bus.o_Mem_Req, bus.o_Lectura_Escritura}, {1'b1, 1'b1});
        repeat (3) step();
        chk("st_req_hold", {bus.o_Mem_Req, bus.o_Lectura_Escritura, bus.o_Reg_Wr_En}, {1'b1, 1'b1, 1'b0});
        bus.i_Mem_Listo = 1'b1;
        step();
        bus.i_Mem_Listo = 1'b0;
        chk("st_done", {bus.o_Mem_Req, bus.o_Lectura_Escritura, bus.o_Reg_Wr_En}, 32'd0);
        chk("st_pc", bus.o_Direcciones_Instrucciones, 32'd1);
        step();
        chk("st_no_wr", bus.o_Reg_Wr_En, 32'd0);

        // HALT
        fill_nop();
        imem[2] = 9'b111_000_000;
        do_reset();
        repeat (8) step();
        chk("halt_state", {bus.o_Halt, bus.o_Estado}, {1'b1, 3'd4});
        repeat (10) step();
        chk("halt_pc_frozen", bus.o_Direcciones_Instrucciones, 32'd2);
        chk("halt_quiet", {bus.o_Halt, bus.o_Mem_Req, bus.o_Reg_Wr_En, bus.o_Estado}, {1'b1, 1'b0, 1'b0, 3'd4});
        rst = 1'b1;
        step();
        chk("halt_reset", {bus.o_Halt, bus.o_Estado, bus.o_Direcciones_Instrucciones}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of MEM
        fill_nop();
        imem[0] = 9'b000_001_100;
        do_reset();
        repeat (5) step();
        chk("rmem_in_mem", {bus.o_Mem_Req, bus.o_Estado}, {1'b1, 3'd3});
        rst = 1'b1;
        step();
        chk("rmem_outs", all_outs(), 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
